// File: rtl/seq_mult32.sv
// seq_mult32: sequential 32x32 unsigned shift-add multiplier.
// Retires one partial product per clock. A rising edge on init loads the
// operands, and 32 BUSY steps later the exact 64-bit product appears on
// res_up/res_dn with ready high.
module seq_mult32 #(
   parameter int freq_hz = 25000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] A_in,
   input  logic [31:0] B_in,
   input  logic        init,
   output logic        ready,
   output logic [31:0] res_up,
   output logic [31:0] res_dn
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // freq_hz is informational only. This empty block is elaborated only
   // for a nonsensical value, so the parameter has a visible use.
   if (freq_hz <= 0) begin : g_freq_invalid
   end

   logic        init_d;
   logic [31:0] mcand;
   logic [64:0] prod;        // {carry, upper32, lower32}
   logic [5:0]  cnt;
   logic [1:0]  state;

   logic        start;
   logic [32:0] upper_sum;
   logic [64:0] prod_shift;

   // Start detection and one shift-add step of the working register.
   always_comb begin
      start      = init & ~init_d;
      upper_sum  = prod[64:32];
      if (prod[0]) begin
         upper_sum = prod[64:32] + {1'b0, mcand};
      end
      prod_shift = {1'b0, upper_sum, prod[31:1]};
   end

   // Control FSM, datapath registers and result capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         // init_d resets high so an init already high across reset does not start.
         init_d <= 1'b1;
         mcand  <= '0;
         prod   <= '0;
         cnt    <= '0;
         state  <= IDLE;
         ready  <= 1'b0;
         res_up <= '0;
         res_dn <= '0;
      end else begin
         init_d <= init;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  mcand <= A_in;
                  prod  <= {33'b0, B_in};
                  cnt   <= '0;
                  ready <= 1'b0;
                  state <= BUSY;
               end
            end
            BUSY: begin
               // A start edge seen here is ignored; init_d still tracks init.
               prod <= prod_shift;
               cnt  <= cnt + 6'd1;
               if (cnt == 6'd31) begin
                  res_up <= prod_shift[63:32];
                  res_dn <= prod_shift[31:0];
                  ready  <= 1'b1;
                  state  <= DONE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mult32.sv
// tb_seq_mult32: directed-vector bench for seq_mult32.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_seq_mult32;

   logic        clk;
   logic        reset;
   logic [31:0] A_in;
   logic [31:0] B_in;
   logic        init;
   logic        ready;
   logic [31:0] res_up;
   logic [31:0] res_dn;

   int n_checks;
   int n_pass;

   seq_mult32 #(.freq_hz(25000000)) dut (
      .clk    (clk),
      .reset  (reset),
      .A_in   (A_in),
      .B_in   (B_in),
      .init   (init),
      .ready  (ready),
      .res_up (res_up),
      .res_dn (res_dn)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      n_checks = n_checks + 1;
      if (observed === expected) begin
         n_pass = n_pass + 1;
      end else begin
         $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, observed, expected);
      end
   endtask

   // Runs one operation. init must already have been low across a rising edge.
   // On return, init is still high and the completion edge E32 has just passed.
   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] prev, input logic [63:0] expected);
      A_in = a;
      B_in = b;
      init = 1'b1;
      @(negedge clk);                       // E0 has passed
      check({tag, "_ready_e0"}, {63'b0, ready}, 64'd0);
      check({tag, "_hold_e0"}, {res_up, res_dn}, prev);
      A_in = ~a;                            // operands after start must not matter
      B_in = ~b;
      repeat (31) @(negedge clk);           // E31 has passed
      check({tag, "_ready_e31"}, {63'b0, ready}, 64'd0);
      check({tag, "_hold_e31"}, {res_up, res_dn}, prev);
      @(negedge clk);                       // E32 has passed
      check({tag, "_ready_e32"}, {63'b0, ready}, 64'd1);
      check({tag, "_product"}, {res_up, res_dn}, expected);
      $display("op %s: A=0x%08h B=0x%08h -> ready=%0b res=0x%08h_%08h", tag, a, b, ready, res_up, res_dn);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      init     = 1'b0;
      A_in     = '0;
      B_in     = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_ready", {63'b0, ready}, 64'd0);
      check("reset_result", {res_up, res_dn}, 64'd0);
      @(negedge clk);

      // Small product, then output stability
      run_op("mul_3x5", 32'd3, 32'd5, 64'd0, 64'h0000_0000_0000_000F);
      init = 1'b0;
      repeat (5) @(negedge clk);
      check("stable_ready", {63'b0, ready}, 64'd1);
      check("stable_result", {res_up, res_dn}, 64'h0000_0000_0000_000F);

      // Maximal operands
      run_op("mul_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_000F,
             64'hFFFF_FFFE_0000_0001);
      init = 1'b0;
      @(negedge clk);

      // Carry into the upper word
      run_op("mul_msb", 32'h8000_0000, 32'd2, 64'hFFFF_FFFE_0000_0001, 64'h0000_0001_0000_0000);
      init = 1'b0;
      @(negedge clk);

      // Zero multiplicand; previous result shown while busy
      run_op("mul_zero", 32'd0, 32'h1234_5678, 64'h0000_0001_0000_0000, 64'd0);
      init = 1'b0;
      @(negedge clk);

      // init held high for about 100 cycles gives exactly one operation
      run_op("hold_init", 32'd7, 32'd9, 64'd0, 64'h0000_0000_0000_003F);
      repeat (70) @(negedge clk);
      check("hold_ready", {63'b0, ready}, 64'd1);
      check("hold_result", {res_up, res_dn}, 64'h0000_0000_0000_003F);
      init = 1'b0;
      @(negedge clk);
      run_op("restart", 32'h0001_0000, 32'h0001_0000, 64'h0000_0000_0000_003F,
             64'h0000_0001_0000_0000);
      init = 1'b0;
      @(negedge clk);

      // A second init edge during BUSY is ignored and not queued
      A_in = 32'h0000_1234;
      B_in = 32'h0000_0010;
      init = 1'b1;
      @(negedge clk);                       // E0
      check("busy_tog_ready_e0", {63'b0, ready}, 64'd0);
      repeat (4) @(negedge clk);            // E4
      init = 1'b0;
      A_in = 32'hFFFF_FFFF;
      B_in = 32'hFFFF_FFFF;
      @(negedge clk);                       // E5
      init = 1'b1;
      repeat (26) @(negedge clk);           // E31
      check("busy_tog_ready_e31", {63'b0, ready}, 64'd0);
      @(negedge clk);                       // E32
      check("busy_tog_ready_e32", {63'b0, ready}, 64'd1);
      check("busy_tog_product", {res_up, res_dn}, 64'h0000_0000_0001_2340);
      repeat (40) @(negedge clk);
      check("busy_tog_no_queue_ready", {63'b0, ready}, 64'd1);
      check("busy_tog_no_queue_result", {res_up, res_dn}, 64'h0000_0000_0001_2340);
      $display("op busy_toggle: res=0x%08h_%08h ready=%0b", res_up, res_dn, ready);
      init = 1'b0;
      @(negedge clk);

      // Reset in the middle of BUSY with init held high
      A_in = 32'd5;
      B_in = 32'd6;
      init = 1'b1;
      repeat (11) @(negedge clk);           // E10
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_ready", {63'b0, ready}, 64'd0);
      check("abort_result", {res_up, res_dn}, 64'd0);
      repeat (40) @(negedge clk);
      check("abort_no_start_ready", {63'b0, ready}, 64'd0);
      check("abort_no_start_result", {res_up, res_dn}, 64'd0);
      $display("op abort: ready=%0b res=0x%08h_%08h", ready, res_up, res_dn);
      init = 1'b0;
      @(negedge clk);
      run_op("after_abort", 32'd3, 32'd4, 64'd0, 64'h0000_0000_0000_000C);
      init = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
